rs_dispatch: RTL and testbench

RS_DISPATCH -- requirements
Module: rs_dispatch

---
 rtl/rs_dispatch_pkg.sv | 29 ++
 rtl/rs_pick_first.sv | 21 ++
 rtl/rs_dispatch.sv | 149 ++++++++++++++
 tb/tb_rs_dispatch.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/rs_dispatch_pkg.sv
// Shared opcodes and the reservation-station entry layout for rs_dispatch.
package rs_dispatch_pkg;

  localparam int RS_DW = 8;
  localparam int RS_TW = 3;

  localparam logic [3:0] FN_ADD = 4'b0000;
  localparam logic [3:0] FN_SUB = 4'b0001;
  localparam logic [3:0] FN_MUL = 4'b0010;
  localparam logic [3:0] FN_DIV = 4'b0011;
  localparam logic [3:0] FN_LD  = 4'b0100;
  localparam logic [3:0] FN_ST  = 4'b0101;

  // Field widths follow RS_DW/RS_TW; rs_dispatch defaults DW/TW to these.
  typedef struct packed {
    logic             busy;
    logic             inflight;
    logic [3:0]       func;
    logic [3:0]       rd;
    logic [RS_TW-1:0] rob;
    logic [RS_DW-1:0] v1;
    logic [RS_TW-1:0] q1;
    logic             r1;
    logic [RS_DW-1:0] v2;
    logic [RS_TW-1:0] q2;
    logic             r2;
  } rs_ent_t;

endpackage

// File: rtl/rs_pick_first.sv
// Lowest-index priority selector: one-hot grant plus an any-request flag.
module rs_pick_first #(
  parameter int N = 3
) (
  input  logic [N-1:0] req,
  output logic [N-1:0] gnt,
  output logic         any
);

  always_comb begin
    gnt = '0;
    any = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (req[i] && !any) begin
        gnt[i] = 1'b1;
        any    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rs_dispatch.sv
// Reservation station: issue into free slots, CDB wakeup, in-order-by-index
// dispatch to a single execution unit, and free-on-completion.
module rs_dispatch
  import rs_dispatch_pkg::*;
#(
  parameter int NUM_ENT = 3,
  parameter int DW      = RS_DW,
  parameter int TW      = RS_TW
) (
  input  logic          clk1,
  input  logic          rst,
  input  logic          iss_valid,
  output logic          iss_ready,
  input  logic [3:0]    iss_func,
  input  logic [3:0]    iss_rd,
  input  logic [TW-1:0] iss_rob,
  input  logic [DW-1:0] iss_v1,
  input  logic [DW-1:0] iss_v2,
  input  logic [TW-1:0] iss_q1,
  input  logic [TW-1:0] iss_q2,
  input  logic          iss_r1,
  input  logic          iss_r2,
  input  logic          cdb_valid,
  input  logic [TW-1:0] cdb_rob,
  input  logic [DW-1:0] cdb_data,
  input  logic          exec_ready,
  output logic          exec_b,
  output logic [3:0]    func,
  output logic [DW-1:0] rs1_data,
  output logic [DW-1:0] rs2_data,
  output logic [TW-1:0] rob_ind,
  output logic [3:0]    rd,
  output logic [TW-1:0] rs_index,
  input  logic          flush
);

  rs_ent_t ent   [NUM_ENT];
  rs_ent_t ent_n [NUM_ENT];
  rs_ent_t sel;

  logic [NUM_ENT-1:0] free_vec, rdy_vec, free_gnt, disp_gnt;
  logic               any_free, any_rdy, do_iss, do_disp, hit1, hit2;
  logic [TW-1:0]      sel_idx;

  // Eligibility looks only at registered state, so a wakeup is never
  // bypassed straight into dispatch and a freed slot is not reused same cycle.
  always_comb begin
    free_vec = '0;
    rdy_vec  = '0;
    for (int i = 0; i < NUM_ENT; i++) begin
      free_vec[i] = !ent[i].busy;
      rdy_vec[i]  = ent[i].busy && !ent[i].inflight && ent[i].r1 && ent[i].r2;
    end
  end

  rs_pick_first #(.N(NUM_ENT)) u_pick_free (.req(free_vec), .gnt(free_gnt), .any(any_free));
  rs_pick_first #(.N(NUM_ENT)) u_pick_disp (.req(rdy_vec),  .gnt(disp_gnt), .any(any_rdy));

  assign iss_ready = any_free;
  assign do_iss    = iss_valid && any_free && !flush;
  assign do_disp   = exec_ready && any_rdy && !flush;
  assign hit1      = cdb_valid && !iss_r1 && (iss_q1 == cdb_rob);
  assign hit2      = cdb_valid && !iss_r2 && (iss_q2 == cdb_rob);

  always_comb begin
    sel     = '0;
    sel_idx = '0;
    for (int i = 0; i < NUM_ENT; i++) begin
      if (disp_gnt[i]) begin
        sel     = ent[i];
        sel_idx = TW'(i);
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_ENT; i++) begin
      ent_n[i] = ent[i];
      if (cdb_valid && ent[i].busy) begin
        if (ent[i].inflight) begin
          if (ent[i].rob == cdb_rob) begin
            ent_n[i].busy     = 1'b0;
            ent_n[i].inflight = 1'b0;
          end
        end else begin
          if (!ent[i].r1 && ent[i].q1 == cdb_rob) begin
            ent_n[i].v1 = cdb_data;
            ent_n[i].r1 = 1'b1;
          end
          if (!ent[i].r2 && ent[i].q2 == cdb_rob) begin
            ent_n[i].v2 = cdb_data;
            ent_n[i].r2 = 1'b1;
          end
        end
      end
      if (do_disp && disp_gnt[i])
        ent_n[i].inflight = 1'b1;
      if (do_iss && free_gnt[i]) begin
        ent_n[i].busy     = 1'b1;
        ent_n[i].inflight = 1'b0;
        ent_n[i].func     = iss_func;
        ent_n[i].rd       = iss_rd;
        ent_n[i].rob      = iss_rob;
        ent_n[i].q1       = iss_q1;
        ent_n[i].q2       = iss_q2;
        ent_n[i].v1       = hit1 ? cdb_data : iss_v1;
        ent_n[i].v2       = hit2 ? cdb_data : iss_v2;
        ent_n[i].r1       = iss_r1 || hit1;
        ent_n[i].r2       = iss_r2 || hit2;
      end
      if (flush) begin
        ent_n[i].busy     = 1'b0;
        ent_n[i].inflight = 1'b0;
      end
    end
  end

  always_ff @(posedge clk1) begin
    if (rst) begin
      for (int i = 0; i < NUM_ENT; i++) ent[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_ENT; i++) ent[i] <= ent_n[i];
    end
  end

  // Payload only moves on a dispatch so it holds while exec_b is low.
  always_ff @(posedge clk1) begin
    if (rst) begin
      exec_b   <= 1'b0;
      func     <= '0;
      rs1_data <= '0;
      rs2_data <= '0;
      rob_ind  <= '0;
      rd       <= '0;
      rs_index <= '0;
    end else begin
      exec_b <= do_disp;
      if (do_disp) begin
        func     <= sel.func;
        rs1_data <= sel.v1;
        rs2_data <= sel.v2;
        rob_ind  <= sel.rob;
        rd       <= sel.rd;
        rs_index <= sel_idx;
      end
    end
  end

endmodule

// File: tb/tb_rs_dispatch.sv
// Cycle-vector bench for rs_dispatch plus a hand-written wakeup latency sequence.
module tb_rs_dispatch;
  import rs_dispatch_pkg::*;

  logic       clk1 = 1'b0, rst, flush;
  logic       iss_valid, iss_ready, iss_r1, iss_r2, cdb_valid, exec_ready, exec_b;
  logic [3:0] iss_func, iss_rd, func, rd;
  logic [2:0] iss_rob, iss_q1, iss_q2, cdb_rob, rob_ind, rs_index;
  logic [7:0] iss_v1, iss_v2, cdb_data, rs1_data, rs2_data;

  int pass_cnt = 0;
  int total    = 0;

  always #5 clk1 = ~clk1;

  rs_dispatch dut (
    .clk1(clk1), .rst(rst), .iss_valid(iss_valid), .iss_ready(iss_ready),
    .iss_func(iss_func), .iss_rd(iss_rd), .iss_rob(iss_rob),
    .iss_v1(iss_v1), .iss_v2(iss_v2), .iss_q1(iss_q1), .iss_q2(iss_q2),
    .iss_r1(iss_r1), .iss_r2(iss_r2), .cdb_valid(cdb_valid), .cdb_rob(cdb_rob),
    .cdb_data(cdb_data), .exec_ready(exec_ready), .exec_b(exec_b), .func(func),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .rob_ind(rob_ind), .rd(rd),
    .rs_index(rs_index), .flush(flush)
  );

  typedef struct {
    logic       rst, fl, iv;
    logic [3:0] fn, rd;
    logic [2:0] rob;
    logic [7:0] v1;
    logic [2:0] q1;
    logic       r1;
    logic [7:0] v2;
    logic [2:0] q2;
    logic       r2, cv;
    logic [2:0] crob;
    logic [7:0] cd;
    logic       er;
    logic       xr, xb;
    logic [3:0] xfn;
    logic [7:0] xd1, xd2;
    logic [2:0] xrob, xidx;
    logic [3:0] xrd;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(int rs, int fl, int iv, int fn, int rdv, int rob,
                              int v1, int q1, int r1, int v2, int q2, int r2,
                              int cv, int crob, int cd, int er,
                              int xr, int xb, int xfn, int xd1, int xd2,
                              int xrob, int xidx, int xrd);
    vec_t t;
    t.rst = 1'(rs);  t.fl = 1'(fl);   t.iv = 1'(iv);   t.fn = 4'(fn);
    t.rd  = 4'(rdv); t.rob = 3'(rob); t.v1 = 8'(v1);   t.q1 = 3'(q1);
    t.r1  = 1'(r1);  t.v2 = 8'(v2);   t.q2 = 3'(q2);   t.r2 = 1'(r2);
    t.cv  = 1'(cv);  t.crob = 3'(crob); t.cd = 8'(cd); t.er = 1'(er);
    t.xr  = 1'(xr);  t.xb = 1'(xb);   t.xfn = 4'(xfn); t.xd1 = 8'(xd1);
    t.xd2 = 8'(xd2); t.xrob = 3'(xrob); t.xidx = 3'(xidx); t.xrd = 4'(xrd);
    return t;
  endfunction

  task automatic drive(input vec_t t);
    rst = t.rst; flush = t.fl; iss_valid = t.iv; iss_func = t.fn; iss_rd = t.rd;
    iss_rob = t.rob; iss_v1 = t.v1; iss_q1 = t.q1; iss_r1 = t.r1;
    iss_v2 = t.v2; iss_q2 = t.q2; iss_r2 = t.r2;
    cdb_valid = t.cv; cdb_rob = t.crob; cdb_data = t.cd; exec_ready = t.er;
  endtask

  task automatic chk(input string nm, input int row, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) pass_cnt++;
    else $display("FAIL row%0d %s: got %0h want %0h", row, nm, act, exp);
  endtask

  task automatic step();
    @(posedge clk1);
    #1;
  endtask

  initial begin
    int n;
    vec_t h;
    //               rs fl iv fn      rd rob v1 q1 r1 v2 q2 r2 cv cr cd er | xr xb xfn     d1 d2 rob idx rd
    tbl.push_back(mk(1, 0, 0, 0,      0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  1, 0, 0,      0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, FN_ADD, 2, 1,  5, 0, 1, 3, 0, 1, 0, 0, 0, 1,  1, 0, 0,      0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0,      0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 1,  1, 1, FN_ADD, 5, 3, 1, 0, 2));
    tbl.push_back(mk(0, 0, 0, 0,      0, 0,  0, 0, 0, 0, 0, 0, 1, 1, 8, 1,  1, 0, FN_ADD, 5, 3, 1, 0, 2));
    tbl.push_back(mk(0, 0, 1, FN_MUL, 3, 2,  0, 4, 0, 7, 0, 1, 0, 0, 0, 1,  1, 0, FN_ADD, 5, 3, 1, 0, 2));
    tbl.push_back(mk(0, 0, 0, 0,      0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 1,  1, 0, FN_ADD, 5, 3, 1, 0, 2));
    tbl.push_back(mk(0, 0, 0, 0,      0, 0,  0, 0, 0, 0, 0, 0, 1, 4, 6, 1,  1, 0, FN_ADD, 5, 3, 1, 0, 2));
    tbl.push_back(mk(0, 0, 0, 0,      0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 1,  1, 1, FN_MUL, 6, 7, 2, 0, 3));
    tbl.push_back(mk(0, 0, 0, 0,      0, 0,  0, 0, 0, 0, 0, 0, 1, 2, 0, 1,  1, 0, FN_MUL, 6, 7, 2, 0, 3));
    tbl.push_back(mk(0, 0, 1, FN_SUB, 1, 5,  4, 0, 1, 0, 3, 0, 1, 3, 9, 1,  1, 0, FN_MUL, 6, 7, 2, 0, 3));
    tbl.push_back(mk(0, 0, 0, 0,      0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 1,  1, 1, FN_SUB, 4, 9, 5, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0,      0, 0,  0, 0, 0, 0, 0, 0, 1, 5, 0, 1,  1, 0, FN_SUB, 4, 9, 5, 0, 1));
    // fill all three slots, then refill the one freed by completion
    tbl.push_back(mk(0, 0, 1, FN_ADD, 0, 1,  1, 0, 1, 2, 0, 1, 0, 0, 0, 1,  1, 0, FN_SUB, 4, 9, 5, 0, 1));
    tbl.push_back(mk(0, 0, 1, FN_LD,  4, 2,  0, 6, 0, 0, 0, 1, 0, 0, 0, 1,  1, 1, FN_ADD, 1, 2, 1, 0, 0));
    tbl.push_back(mk(0, 0, 1, FN_ST,  5, 3,  0, 7, 0, 0, 7, 0, 0, 0, 0, 1,  0, 0, FN_ADD, 1, 2, 1, 0, 0));
    tbl.push_back(mk(0, 0, 1, FN_DIV, 6, 4, 12, 0, 1, 4, 0, 1, 1, 1, 0, 1,  1, 0, FN_ADD, 1, 2, 1, 0, 0));
    tbl.push_back(mk(0, 0, 1, FN_DIV, 6, 4, 12, 0, 1, 4, 0, 1, 0, 0, 0, 1,  0, 0, FN_ADD, 1, 2, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0,      0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 1,  0, 1, FN_DIV,12, 4, 4, 0, 6));
    tbl.push_back(mk(0, 1, 0, 0,      0, 0,  0, 0, 0, 0, 0, 0, 1, 6, 1, 1,  1, 0, FN_DIV,12, 4, 4, 0, 6));
    tbl.push_back(mk(0, 0, 0, 0,      0, 0,  0, 0, 0, 0, 0, 0, 1, 4,99, 1,  1, 0, FN_DIV,12, 4, 4, 0, 6));
    // two ready entries held back by exec_ready
    tbl.push_back(mk(0, 0, 1, FN_ADD, 7, 1, 10, 0, 1,20, 0, 1, 0, 0, 0, 0,  1, 0, FN_DIV,12, 4, 4, 0, 6));
    tbl.push_back(mk(0, 0, 1, FN_SUB, 8, 2, 30, 0, 1, 5, 0, 1, 0, 0, 0, 0,  1, 0, FN_DIV,12, 4, 4, 0, 6));
    tbl.push_back(mk(0, 0, 0, 0,      0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  1, 0, FN_DIV,12, 4, 4, 0, 6));
    tbl.push_back(mk(0, 0, 0, 0,      0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 1,  1, 1, FN_ADD,10,20, 1, 0, 7));
    tbl.push_back(mk(0, 0, 0, 0,      0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 1,  1, 1, FN_SUB,30, 5, 2, 1, 8));
    tbl.push_back(mk(0, 0, 0, 0,      0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 1,  1, 0, FN_SUB,30, 5, 2, 1, 8));
    // flush with one EXEC and one ready WAIT entry
    tbl.push_back(mk(0, 0, 0, 0,      0, 0,  0, 0, 0, 0, 0, 0, 1, 1, 0, 0,  1, 0, FN_SUB,30, 5, 2, 1, 8));
    tbl.push_back(mk(0, 0, 1, FN_MUL,11, 3,  2, 0, 1, 2, 0, 1, 0, 0, 0, 0,  1, 0, FN_SUB,30, 5, 2, 1, 8));
    tbl.push_back(mk(0, 1, 0, 0,      0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 1,  1, 0, FN_SUB,30, 5, 2, 1, 8));
    tbl.push_back(mk(0, 0, 0, 0,      0, 0,  0, 0, 0, 0, 0, 0, 1, 2, 0, 1,  1, 0, FN_SUB,30, 5, 2, 1, 8));
    tbl.push_back(mk(0, 0, 0, 0,      0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 1,  1, 0, FN_SUB,30, 5, 2, 1, 8));
    // reset with one EXEC and one ready WAIT entry
    tbl.push_back(mk(0, 0, 1, FN_ADD, 9, 5,  1, 0, 1, 1, 0, 1, 0, 0, 0, 0,  1, 0, FN_SUB,30, 5, 2, 1, 8));
    tbl.push_back(mk(0, 0, 1, FN_SUB,12, 6,  2, 0, 1, 2, 0, 1, 0, 0, 0, 1,  1, 1, FN_ADD, 1, 1, 5, 0, 9));
    tbl.push_back(mk(1, 0, 0, 0,      0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 1,  1, 0, 0,      0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0,      0, 0,  0, 0, 0, 0, 0, 0, 1, 5, 0, 1,  1, 0, 0,      0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, FN_ADD,10, 7,  3, 0, 1, 4, 0, 1, 0, 0, 0, 1,  1, 0, 0,      0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0,      0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 1,  1, 1, FN_ADD, 3, 4, 7, 0,10));

    drive(mk(1,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0,0));
    step();
    foreach (tbl[r]) begin
      drive(tbl[r]);
      step();
      chk("iss_ready", r, 32'(iss_ready), 32'(tbl[r].xr));
      chk("exec_b",    r, 32'(exec_b),    32'(tbl[r].xb));
      chk("func",      r, 32'(func),      32'(tbl[r].xfn));
      chk("rs1_data",  r, 32'(rs1_data),  32'(tbl[r].xd1));
      chk("rs2_data",  r, 32'(rs2_data),  32'(tbl[r].xd2));
      chk("rob_ind",   r, 32'(rob_ind),   32'(tbl[r].xrob));
      chk("rs_index",  r, 32'(rs_index),  32'(tbl[r].xidx));
      chk("rd",        r, 32'(rd),        32'(tbl[r].xrd));
    end

    // Wakeup-to-dispatch latency: one cycle of eligibility delay, single-cycle pulse.
    drive(mk(0,0,0,0,0,0,0,0,0,0,0,0,1,7,0,1, 0,0,0,0,0,0,0,0));
    step();
    drive(mk(0,0,1,FN_MUL,1,3,0,2,0,5,0,1,0,0,0,1, 0,0,0,0,0,0,0,0));
    step();
    chk("seq_wait_b", 100, 32'(exec_b), 32'd0);
    h = mk(0,0,0,0,0,0,0,0,0,0,0,0,1,2,11,1, 0,0,0,0,0,0,0,0);
    drive(h);
    step();
    chk("seq_nobypass_b", 101, 32'(exec_b), 32'd0);
    drive(mk(0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,1, 0,0,0,0,0,0,0,0));
    n = 0;
    while (!exec_b && n < 8) begin
      step();
      n++;
    end
    chk("seq_latency",  102, 32'(n),        32'd1);
    chk("seq_rs1_data", 103, 32'(rs1_data), 32'd11);
    chk("seq_rs2_data", 104, 32'(rs2_data), 32'd5);
    chk("seq_rs_index", 105, 32'(rs_index), 32'd0);
    chk("seq_func",     106, 32'(func),     32'(FN_MUL));
    drive(mk(0,0,0,0,0,0,0,0,0,0,0,0,1,6,0,1, 0,0,0,0,0,0,0,0));
    step();
    chk("seq_pulse_b",  107, 32'(exec_b),    32'd0);
    chk("seq_nomatch",  108, 32'(iss_ready), 32'd1);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running want finished");
    $fatal(1, "timeout");
  end

endmodule
